render_frame_scheduler: RTL and testbench
=========================================

Name: render_frame_scheduler

Overview:
- Per-frame sequencer for the render pipeline.
- On a frame request it does the following, in order:
  - triggers a framebuffer clear;
  - for each of N objects, pops one object descriptor (model index) from the object FIFO;
  - re-arms the model reader for that model;
  - starts the render pipeline and waits for it to finish.
- Then it reports frame completion.
- Sits between the frame/host control logic and the model_reader + render_pipeline pair, replacing hand-driven start/reset strobes.

Parameters:
- MODEL_INDEX_WIDTH, 4: width of model index to model_reader.
- MAX_NUM_OBJECTS_PER_FRAME, 1024: max objects per frame.
- OBJ_COUNT_WIDTH, $clog2(MAX_NUM_OBJECTS_PER_FRAME+1): width of object counts.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- i_frame_start  in  1  frame request pulse; accepted only in IDLE.
- i_num_objects  in  OBJ_COUNT_WIDTH  objects this frame; sampled with i_frame_start.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse at end of frame.
- o_objects_rendered  out  OBJ_COUNT_WIDTH  objects completed this frame.
- o_clear_start  out  1  one-cycle framebuffer clear request.
- i_clear_done  in  1  clear complete pulse.
- o_obj_read_en  out  1  object FIFO pop, one cycle.
- i_obj_empty  in  1  object FIFO empty.
- i_obj_dv  in  1  descriptor valid.
- i_obj_model_index  in  MODEL_INDEX_WIDTH  descriptor model index.
- o_model_reader_reset  out  1  one-cycle model_reader reset.
- o_model_index  out  MODEL_INDEX_WIDTH  model selected for model_reader.
- i_model_reader_ready  in  1  model_reader ready.
- o_pipe_start  out  1  one-cycle render_pipeline start.
- i_pipe_ready  in  1  render_pipeline ready.
- i_pipe_finished  in  1  render_pipeline finished pulse.

Behaviour:
- Clock and reset: single clock clk. rstn is synchronous, active-low.
- Reset values:
  - State = IDLE.
  - All outputs 0, including o_model_index, o_objects_rendered and o_busy.
  - Latched object count = 0.
- Reset mid-frame: returns to IDLE next edge. No o_frame_done is emitted; in-flight strobes drop.
- Strobes: o_clear_start, o_obj_read_en, o_model_reader_reset, o_pipe_start and o_frame_done are registered and high for exactly one cycle per event.
- IDLE:
  - On i_frame_start: latch i_num_objects, clear o_objects_rendered, pulse o_clear_start, go to CLEAR.
  - If i_num_objects > MAX_NUM_OBJECTS_PER_FRAME, clamp to MAX.
- CLEAR: wait for i_clear_done.
  - Latched count == 0: go to DONE.
  - Otherwise: go to FETCH.
- FETCH:
  - While i_obj_empty=1, wait. No pop is issued.
  - Otherwise pulse o_obj_read_en and go to WAIT_OBJ.
- WAIT_OBJ: wait for i_obj_dv (any latency ≥1 cycle). Latch i_obj_model_index into o_model_index, go to LOAD.
- LOAD: pulse o_model_reader_reset, go to WAIT_MODEL.
  - o_model_index stays stable from LOAD until the next WAIT_OBJ capture.
- WAIT_MODEL:
  - i_model_reader_ready is ignored in the first cycle of this state (stale-ready guard).
  - From the second cycle on, ready=1 moves to START.
- START: wait for i_pipe_ready=1, then pulse o_pipe_start and go to RENDER.
  - Earliest o_pipe_start is the cycle after entering START.
- RENDER: wait for i_pipe_finished, then increment o_objects_rendered.
  - New count == latched count: go to DONE.
  - Otherwise: go to FETCH.
- DONE: pulse o_frame_done, go to IDLE. o_objects_rendered holds until the next accepted frame start.
- Ignored inputs and error cases:
  - i_frame_start outside IDLE is ignored, including in the DONE cycle.
  - i_pipe_finished outside RENDER is ignored.
  - i_clear_done outside CLEAR is ignored.
  - i_obj_dv outside WAIT_OBJ is ignored.
  - The counter never wraps: the count reaching the latched value always ends the frame.

Test Plan:
- Frame, N=2, model indices 3 then 5, clear_done 4 cycles after o_clear_start, immediate readies, finished 10 cycles after each start -> sequence is clear, pop, reset with o_model_index=3, start, pop, reset with o_model_index=5, start. One o_frame_done; o_objects_rendered=2.
- N=0 -> o_clear_start, then o_frame_done the cycle after i_clear_done; no o_obj_read_en, o_model_reader_reset or o_pipe_start.
- N=1, i_obj_empty held 1 for 20 cycles, i_model_reader_ready stuck at 1 -> no pop until empty drops. o_pipe_start no earlier than 2 cycles after o_model_reader_reset (stale ready ignored).
- i_frame_start pulsed during RENDER and in the DONE cycle, spurious i_pipe_finished during WAIT_MODEL -> no effect; count and state sequence unchanged.
- rstn low for 1 cycle during RENDER of object 2 of 3 -> all outputs 0 next cycle, o_busy=0, no o_frame_done. A new i_frame_start with N=1 completes normally with o_objects_rendered=1.
- i_num_objects=2000 -> frame ends after exactly 1024 finished pulses.

Source files
------------

// File: rtl/render_frame_scheduler.sv
// Per-frame sequencer: clears the framebuffer, then for each object pops a descriptor,
// re-arms the model reader and runs the render pipeline, finally pulsing frame done.
module render_frame_scheduler #(
    parameter int MODEL_INDEX_WIDTH         = 4,
    parameter int MAX_NUM_OBJECTS_PER_FRAME = 1024,
    parameter int OBJ_COUNT_WIDTH           = $clog2(MAX_NUM_OBJECTS_PER_FRAME + 1)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_frame_start,
    input  logic [OBJ_COUNT_WIDTH-1:0]   i_num_objects,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic [OBJ_COUNT_WIDTH-1:0]   o_objects_rendered,
    output logic                         o_clear_start,
    input  logic                         i_clear_done,
    output logic                         o_obj_read_en,
    input  logic                         i_obj_empty,
    input  logic                         i_obj_dv,
    input  logic [MODEL_INDEX_WIDTH-1:0] i_obj_model_index,
    output logic                         o_model_reader_reset,
    output logic [MODEL_INDEX_WIDTH-1:0] o_model_index,
    input  logic                         i_model_reader_ready,
    output logic                         o_pipe_start,
    input  logic                         i_pipe_ready,
    input  logic                         i_pipe_finished
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT_OBJ,
        S_LOAD,
        S_WAIT_MODEL,
        S_START,
        S_RENDER,
        S_DONE
    } state_t;

    localparam logic [OBJ_COUNT_WIDTH-1:0] MAX_COUNT = OBJ_COUNT_WIDTH'(MAX_NUM_OBJECTS_PER_FRAME);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [OBJ_COUNT_WIDTH-1:0]   r_target;
    logic                         r_model_first;
    logic [OBJ_COUNT_WIDTH-1:0]   w_num_clamped;
    logic [OBJ_COUNT_WIDTH-1:0]   w_rendered_inc;
    logic                         w_clear_start;
    logic                         w_obj_read_en;
    logic                         w_model_reader_reset;
    logic                         w_pipe_start;
    logic                         w_frame_done;

    assign w_num_clamped  = (i_num_objects > MAX_COUNT) ? MAX_COUNT : i_num_objects;
    assign w_rendered_inc = o_objects_rendered + 1'b1;
    assign o_busy         = (r_state != S_IDLE);

    // Strobes are computed on the transition into a state and registered, so each
    // one is visible during the first cycle of the state it announces.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state         = r_state;
        w_clear_start        = 1'b0;
        w_obj_read_en        = 1'b0;
        w_model_reader_reset = 1'b0;
        w_pipe_start         = 1'b0;
        w_frame_done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_frame_start) begin
                    w_next_state  = S_CLEAR;
                    w_clear_start = 1'b1;
                end
            end
            S_CLEAR: begin
                if (i_clear_done) begin
                    if (r_target == '0) begin
                        w_next_state = S_DONE;
                        w_frame_done = 1'b1;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (!i_obj_empty) begin
                    w_next_state  = S_WAIT_OBJ;
                    w_obj_read_en = 1'b1;
                end
            end
            S_WAIT_OBJ: begin
                if (i_obj_dv) begin
                    w_next_state         = S_LOAD;
                    w_model_reader_reset = 1'b1;
                end
            end
            S_LOAD: w_next_state = S_WAIT_MODEL;
            S_WAIT_MODEL: begin
                // Ready seen in the first cycle may still belong to the previous model.
                if (!r_model_first && i_model_reader_ready) w_next_state = S_START;
            end
            S_START: begin
                if (i_pipe_ready) begin
                    w_next_state = S_RENDER;
                    w_pipe_start = 1'b1;
                end
            end
            S_RENDER: begin
                if (i_pipe_finished) begin
                    if (w_rendered_inc == r_target) begin
                        w_next_state = S_DONE;
                        w_frame_done = 1'b1;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_clear_start        <= 1'b0;
            o_obj_read_en        <= 1'b0;
            o_model_reader_reset <= 1'b0;
            o_pipe_start         <= 1'b0;
            o_frame_done         <= 1'b0;
            o_objects_rendered   <= '0;
            o_model_index        <= '0;
            r_target             <= '0;
            r_model_first        <= 1'b0;
        end else begin
            o_clear_start        <= w_clear_start;
            o_obj_read_en        <= w_obj_read_en;
            o_model_reader_reset <= w_model_reader_reset;
            o_pipe_start         <= w_pipe_start;
            o_frame_done         <= w_frame_done;
            r_model_first        <= (r_state == S_LOAD);
            if (r_state == S_IDLE && i_frame_start) begin
                r_target           <= w_num_clamped;
                o_objects_rendered <= '0;
            end
            if (r_state == S_WAIT_OBJ && i_obj_dv) o_model_index <= i_obj_model_index;
            if (r_state == S_RENDER && i_pipe_finished) o_objects_rendered <= w_rendered_inc;
        end
    end

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Bench for render_frame_scheduler: reactive models of clear engine, object FIFO, model
// reader and pipeline, with each frame's event log compared against an expected sequence.
module tb_render_frame_scheduler;

    localparam int MIW  = 4;
    localparam int MAXN = 1024;
    localparam int CW   = $clog2(MAXN + 1);

    logic           clk = 1'b0;
    logic           rstn;
    logic           i_frame_start;
    logic [CW-1:0]  i_num_objects;
    logic           o_busy;
    logic           o_frame_done;
    logic [CW-1:0]  o_objects_rendered;
    logic           o_clear_start;
    logic           i_clear_done;
    logic           o_obj_read_en;
    logic           i_obj_empty;
    logic           i_obj_dv;
    logic [MIW-1:0] i_obj_model_index;
    logic           o_model_reader_reset;
    logic [MIW-1:0] o_model_index;
    logic           i_model_reader_ready;
    logic           o_pipe_start;
    logic           i_pipe_ready;
    logic           i_pipe_finished;

    render_frame_scheduler #(
        .MODEL_INDEX_WIDTH(MIW),
        .MAX_NUM_OBJECTS_PER_FRAME(MAXN),
        .OBJ_COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_frame_start(i_frame_start), .i_num_objects(i_num_objects),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_objects_rendered(o_objects_rendered),
        .o_clear_start(o_clear_start), .i_clear_done(i_clear_done),
        .o_obj_read_en(o_obj_read_en), .i_obj_empty(i_obj_empty), .i_obj_dv(i_obj_dv),
        .i_obj_model_index(i_obj_model_index),
        .o_model_reader_reset(o_model_reader_reset), .o_model_index(o_model_index),
        .i_model_reader_ready(i_model_reader_ready),
        .o_pipe_start(o_pipe_start), .i_pipe_ready(i_pipe_ready), .i_pipe_finished(i_pipe_finished)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] kind;
        int         val;
    } ev_t;
    ev_t ev_q[$];
    int  fifo_q[$];

    // Environment knobs set by the test tasks
    int clr_lat = 1, dv_lat = 1, mr_lat = 0, fin_lat = 1, empty_hold = 0;
    bit mr_stuck = 0, pr_rand = 0, spur_en = 0;
    bit start_req = 0;
    int start_n = 0;

    // Environment tracking state
    int cyc = 0, clr_cnt = 0, dv_cnt = 0, mr_cnt = 0, fin_cnt = 0;
    int last_reset_cyc = 0, held_idx = 0, pend_idx = 0;
    bit clr_pend = 0, dv_pend = 0, fin_pend = 0, prev_empty = 1, prev_done = 0;
    int done_cnt = 0, start_cnt = 0;

    function automatic void log_ev(input logic [7:0] k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        ev_q.push_back(e);
    endfunction

    // Single negedge process: observes registered outputs, then drives inputs for the next edge.
    initial begin : env
        i_frame_start = 0; i_num_objects = '0; i_clear_done = 0; i_obj_empty = 1;
        i_obj_dv = 0; i_obj_model_index = '0; i_model_reader_ready = 0;
        i_pipe_ready = 0; i_pipe_finished = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                clr_pend = 0; dv_pend = 0; fin_pend = 0; mr_cnt = 0;
                prev_done = 0; prev_empty = 1; fifo_q.delete();
                i_frame_start = 0; i_clear_done = 0; i_obj_dv = 0;
                i_pipe_finished = 0; i_obj_empty = 1;
            end else begin
                if (prev_done) begin
                    n_checks++;
                    if (o_busy !== 1'b0) $display("FAIL busy_after_done: got %b want 0", o_busy);
                    else n_pass++;
                end
                prev_done = o_frame_done;
                if (o_clear_start) begin
                    log_ev("C", 0);
                    n_checks++;
                    if (o_busy !== 1'b1) $display("FAIL busy_at_clear: got %b want 1", o_busy);
                    else n_pass++;
                    clr_pend = 1; clr_cnt = clr_lat - 1;
                end
                if (o_obj_read_en) begin
                    log_ev("P", 0);
                    n_checks++;
                    if (prev_empty) $display("FAIL pop_while_empty: got pop with empty=1 want no pop");
                    else n_pass++;
                    if (fifo_q.size() > 0) pend_idx = fifo_q.pop_front();
                    else pend_idx = 0;
                    dv_pend = 1; dv_cnt = dv_lat - 1;
                end
                if (o_model_reader_reset) begin
                    log_ev("R", int'(o_model_index));
                    last_reset_cyc = cyc;
                    held_idx = int'(o_model_index);
                    mr_cnt = mr_lat;
                end
                if (o_pipe_start) begin
                    log_ev("S", 0);
                    start_cnt++;
                    n_checks++;
                    if (cyc - last_reset_cyc < 4)
                        $display("FAIL start_gap: got %0d cycles after reset want >=4", cyc - last_reset_cyc);
                    else n_pass++;
                    n_checks++;
                    if (int'(o_model_index) != held_idx)
                        $display("FAIL index_stable: got %0d want %0d", o_model_index, held_idx);
                    else n_pass++;
                    fin_pend = 1; fin_cnt = fin_lat - 1;
                end
                if (o_frame_done) begin
                    log_ev("D", int'(o_objects_rendered));
                    done_cnt++;
                    n_checks++;
                    if (o_busy !== 1'b1) $display("FAIL busy_at_done: got %b want 1", o_busy);
                    else n_pass++;
                end

                i_clear_done = 0;
                if (clr_pend) begin
                    if (clr_cnt == 0) begin i_clear_done = 1; clr_pend = 0; end
                    else clr_cnt--;
                end else if (spur_en && $urandom_range(0, 5) == 0) i_clear_done = 1;

                i_obj_dv = 0;
                i_obj_model_index = MIW'($urandom_range(0, 15));
                if (dv_pend) begin
                    if (dv_cnt == 0) begin
                        i_obj_dv = 1; i_obj_model_index = MIW'(pend_idx); dv_pend = 0;
                    end else dv_cnt--;
                end else if (spur_en && $urandom_range(0, 5) == 0) i_obj_dv = 1;

                if (mr_stuck) i_model_reader_ready = 1;
                else begin
                    i_model_reader_ready = (mr_cnt == 0);
                    if (mr_cnt > 0) mr_cnt--;
                end

                i_pipe_ready = pr_rand ? 1'($urandom_range(0, 1)) : 1'b1;

                i_pipe_finished = 0;
                if (fin_pend) begin
                    if (fin_cnt == 0) begin i_pipe_finished = 1; fin_pend = 0; end
                    else fin_cnt--;
                end else if (spur_en && $urandom_range(0, 3) == 0) i_pipe_finished = 1;

                i_obj_empty = (fifo_q.size() == 0) || (empty_hold > 0);
                if (empty_hold > 0) empty_hold--;
                prev_empty = i_obj_empty;

                i_frame_start = 0;
                if (start_req) begin
                    i_frame_start = 1; i_num_objects = CW'(start_n); start_req = 0;
                end else if (spur_en && o_busy && (o_frame_done || $urandom_range(0, 7) == 0)) begin
                    i_frame_start = 1; i_num_objects = CW'($urandom_range(0, 5));
                end
            end
        end
    end

    // Reference: C, then (P, R<index>, S) per object in FIFO order, then D<min(n,MAX)>.
    task automatic run_frame(input int n, input string name);
        int   m;
        int   d0;
        int   bound;
        ev_t  exp_q[$];
        ev_t  e;
        m = (n > MAXN) ? MAXN : n;
        e.kind = "C"; e.val = 0; exp_q.push_back(e);
        for (int i = 0; i < m; i++) begin
            e.kind = "P"; e.val = 0;         exp_q.push_back(e);
            e.kind = "R"; e.val = fifo_q[i]; exp_q.push_back(e);
            e.kind = "S"; e.val = 0;         exp_q.push_back(e);
        end
        e.kind = "D"; e.val = m; exp_q.push_back(e);
        ev_q.delete();
        d0 = done_cnt;
        start_n = n;
        start_req = 1;
        bound = 300 + m * 120;
        while (done_cnt == d0 && bound > 0) begin
            @(posedge clk); #2;
            bound--;
        end
        repeat (4) begin @(posedge clk); #2; end
        n_checks++;
        if (done_cnt != d0 + 1) begin
            $display("FAIL %s frame_done_count: got %0d want 1", name, done_cnt - d0);
            rstn = 0; @(posedge clk); #2; rstn = 1;
        end else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= ev_q.size())
                $display("FAIL %s ev%0d: got none want %s/%0d", name, i, exp_q[i].kind, exp_q[i].val);
            else if (ev_q[i].kind !== exp_q[i].kind || ev_q[i].val != exp_q[i].val)
                $display("FAIL %s ev%0d: got %s/%0d want %s/%0d", name, i,
                         ev_q[i].kind, ev_q[i].val, exp_q[i].kind, exp_q[i].val);
            else n_pass++;
        end
        n_checks++;
        if (ev_q.size() != exp_q.size())
            $display("FAIL %s event_count: got %0d want %0d", name, ev_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic set_env(input int cl, input int dl, input int ml, input int fl,
                           input bit stuck, input bit prr, input bit spur);
        clr_lat = cl; dv_lat = dl; mr_lat = ml; fin_lat = fl;
        mr_stuck = stuck; pr_rand = prr; spur_en = spur;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) begin @(posedge clk); #2; end
        n_checks++;
        if ({o_busy, o_frame_done, o_objects_rendered, o_clear_start, o_obj_read_en,
             o_model_reader_reset, o_model_index, o_pipe_start} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d idx=%0d want all 0",
                     o_busy, o_frame_done, o_objects_rendered, o_model_index);
        else n_pass++;
        rstn = 1;
        repeat (3) begin @(posedge clk); #2; end
        n_checks++;
        if ({o_busy, o_clear_start, o_obj_read_en} !== 3'b000)
            $display("FAIL idle_after_reset: got %b want 000", {o_busy, o_clear_start, o_obj_read_en});
        else n_pass++;
    endtask

    task automatic test_two_objects();
        set_env(4, 1, 0, 10, 0, 0, 0);
        fifo_q.push_back(3);
        fifo_q.push_back(5);
        run_frame(2, "two_objects");
    endtask

    task automatic test_zero_objects();
        set_env(3, 1, 0, 2, 0, 0, 0);
        run_frame(0, "zero_objects");
    endtask

    task automatic test_empty_stall();
        set_env(2, 2, 0, 3, 1, 0, 0);
        fifo_q.push_back(int'($urandom_range(0, 15)));
        empty_hold = 22;
        run_frame(1, "empty_stall");
        mr_stuck = 0;
    endtask

    task automatic test_ignored_inputs();
        set_env(2, 2, 3, 6, 0, 0, 1);
        for (int i = 0; i < 3; i++) fifo_q.push_back(int'($urandom_range(0, 15)));
        run_frame(3, "ignored_inputs");
        spur_en = 0;
    endtask

    task automatic test_mid_frame_reset();
        int d0;
        int s0;
        int bound;
        set_env(2, 1, 0, 20, 0, 0, 0);
        for (int i = 0; i < 3; i++) fifo_q.push_back(int'($urandom_range(0, 15)));
        d0 = done_cnt;
        s0 = start_cnt;
        start_n = 3;
        start_req = 1;
        bound = 1000;
        while (!(start_cnt == s0 + 2 && fin_pend) && bound > 0) begin
            @(posedge clk); #2;
            bound--;
        end
        n_checks++;
        if (bound == 0) $display("FAIL mid_reset_reach_render2: got timeout want second render");
        else n_pass++;
        rstn = 0;
        @(posedge clk); #2;
        n_checks++;
        if ({o_busy, o_frame_done, o_objects_rendered, o_clear_start, o_obj_read_en,
             o_model_reader_reset, o_model_index, o_pipe_start} !== '0)
            $display("FAIL mid_reset_outputs: got busy=%b cnt=%0d idx=%0d want all 0",
                     o_busy, o_objects_rendered, o_model_index);
        else n_pass++;
        rstn = 1;
        repeat (30) begin @(posedge clk); #2; end
        n_checks++;
        if (done_cnt != d0) $display("FAIL mid_reset_no_done: got %0d done pulses want 0", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL mid_reset_idle: got busy=%b want 0", o_busy);
        else n_pass++;
        fin_lat = 3;
        fifo_q.push_back(int'($urandom_range(0, 15)));
        run_frame(1, "after_reset");
    endtask

    task automatic test_clamp();
        set_env(1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < MAXN; i++) fifo_q.push_back(int'($urandom_range(0, 15)));
        run_frame(2000, "clamp");
    endtask

    task automatic test_random_frames();
        int n;
        for (int f = 0; f < 6; f++) begin
            set_env($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 3),
                    $urandom_range(1, 6), 0, 1, 1'($urandom_range(0, 1)));
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) fifo_q.push_back(int'($urandom_range(0, 15)));
            run_frame(n, "random");
        end
        spur_en = 0;
        pr_rand = 0;
    endtask

    initial begin
        rstn = 0;
        test_reset();
        test_two_objects();
        test_zero_objects();
        test_empty_stall();
        test_ignored_inputs();
        test_mid_frame_reset();
        test_clamp();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
